// File: rtl/datamem_bus_pkg.sv
// Shared types and constants for the data-memory bus controller: FSM states,
// default region map and the byte-enable patterns accepted by the alignment check.
package datamem_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   localparam logic [63:0] DEF_REGION_BASE  = {32'h90000000, 32'h10010000};
   localparam logic [63:0] DEF_REGION_LIMIT = {32'h90000FFF, 32'h10011FFF};

   localparam int NUM_LEGAL_BE = 7;
   localparam logic [NUM_LEGAL_BE*4-1:0] LEGAL_BE =
      {4'b1111, 4'b1100, 4'b0011, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

   // A one-region build still needs a 1-bit index
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic be_legal(input logic [3:0] be);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < NUM_LEGAL_BE; i++) begin
         if (LEGAL_BE[i*4 +: 4] == be) ok = 1'b1;
      end
      return ok;
   endfunction

endpackage

// File: rtl/datamem_region_decode.sv
// Combinational address-to-region decode; overlapping regions resolve to the
// lowest index because lower indices are evaluated last and override.
module datamem_region_decode #(
   parameter int                          NUM_REGIONS  = 2,
   parameter int                          IDX_W        = 1,
   parameter logic [NUM_REGIONS*32-1:0]   REGION_BASE  = '0,
   parameter logic [NUM_REGIONS*32-1:0]   REGION_LIMIT = '0
) (
   input  logic [31:0]      addr,
   output logic             hit,
   output logic [IDX_W-1:0] idx
);

   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
         if ((addr >= REGION_BASE[r*32 +: 32]) && (addr <= REGION_LIMIT[r*32 +: 32])) begin
            hit = 1'b1;
            idx = IDX_W'(r);
         end
      end
   end

endmodule

// File: rtl/datamem_bus_ctrl.sv
// Single-outstanding bus to synchronous RAM regions: accept in IDLE, drive RAM in ACCESS, respond in RESP.
// Optional macro DATAMEM_BUS_ALIGN_CHECK_EN rejects non-naturally-aligned byte-enable patterns.
module datamem_bus_ctrl
   import datamem_bus_pkg::*;
#(
   parameter int                        NUM_REGIONS  = 2,
   parameter int                        REGION_AW    = 11,
   parameter logic [NUM_REGIONS*32-1:0] REGION_BASE  = DEF_REGION_BASE,
   parameter logic [NUM_REGIONS*32-1:0] REGION_LIMIT = DEF_REGION_LIMIT
) (
   input  logic                      iCLK,
   input  logic                      iRST,
   input  logic                      iReq,
   input  logic                      iWrite,
   input  logic [3:0]                iByteEnable,
   input  logic [31:0]               iAddress,
   input  logic [31:0]               iWriteData,
   output logic [31:0]               oReadData,
   output logic                      oValid,
   output logic                      oErr,
   output logic                      oBusy,
   output logic [REGION_AW-1:0]      oMemAddr,
   output logic [3:0]                oMemByteEn,
   output logic [31:0]               oMemWData,
   output logic [NUM_REGIONS-1:0]    oMemWren,
   input  logic [NUM_REGIONS*32-1:0] iMemRData
);

   localparam int IDX_W = idx_width(NUM_REGIONS);

   state_e               state_q, state_d;
   logic [REGION_AW-1:0] addr_q, addr_d;
   logic [3:0]           be_q, be_d;
   logic [31:0]          wdata_q, wdata_d;
   logic                 write_q, write_d;
   logic [IDX_W-1:0]     region_q, region_d;
   logic                 err_q, err_d;
   logic [31:0]          rdata_q, rdata_d;

   logic                 dec_hit;
   logic [IDX_W-1:0]     dec_idx;
   logic [31:0]          rdata_sel;
   logic [31:0]          resp_rdata;

   datamem_region_decode #(
      .NUM_REGIONS  (NUM_REGIONS),
      .IDX_W        (IDX_W),
      .REGION_BASE  (REGION_BASE),
      .REGION_LIMIT (REGION_LIMIT)
   ) u_decode (
      .addr (iAddress),
      .hit  (dec_hit),
      .idx  (dec_idx)
   );

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         be_q     <= '0;
         wdata_q  <= '0;
         write_q  <= 1'b0;
         region_q <= '0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         write_q  <= write_d;
         region_q <= region_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (iReq) state_d = ST_ACCESS;
         ST_ACCESS: state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      addr_d   = addr_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      write_d  = write_q;
      region_d = region_q;
      err_d    = err_q;
      rdata_d  = rdata_q;
      if ((state_q == ST_IDLE) && iReq) begin
         addr_d   = iAddress[REGION_AW+1:2];
         be_d     = iByteEnable;
         wdata_d  = iWriteData;
         write_d  = iWrite;
         region_d = dec_idx;
`ifdef DATAMEM_BUS_ALIGN_CHECK_EN
         err_d    = !dec_hit || !be_legal(iByteEnable);
`else
         err_d    = !dec_hit;
`endif
      end
      // Capture the response so oReadData holds it after the pulse
      if (state_q == ST_RESP) rdata_d = resp_rdata;
   end

   always_comb begin
      rdata_sel = '0;
      oMemWren  = '0;
      for (int r = 0; r < NUM_REGIONS; r++) begin
         if (region_q == IDX_W'(r)) begin
            rdata_sel   = iMemRData[r*32 +: 32];
            oMemWren[r] = (state_q == ST_ACCESS) && write_q && !err_q;
         end
      end
      resp_rdata = (!write_q && !err_q) ? rdata_sel : 32'h0;
      oValid     = (state_q == ST_RESP);
      oErr       = (state_q == ST_RESP) && err_q;
      oBusy      = (state_q != ST_IDLE);
      oReadData  = (state_q == ST_RESP) ? resp_rdata : rdata_q;
   end

   assign oMemAddr   = addr_q;
   assign oMemByteEn = be_q;
   assign oMemWData  = wdata_q;

endmodule

// File: tb/tb_datamem_bus_ctrl.sv
// Bench for datamem_bus_ctrl: two synchronous RAMs behind the bus, directed then random
// transactions checked against a byte-addressed reference memory.
module tb_datamem_bus_ctrl;

   logic        iCLK = 1'b0;
   logic        iRST = 1'b1;
   logic        iReq = 1'b0;
   logic        iWrite = 1'b0;
   logic [3:0]  iByteEnable = 4'h0;
   logic [31:0] iAddress = 32'h0;
   logic [31:0] iWriteData = 32'h0;
   logic [31:0] oReadData;
   logic        oValid;
   logic        oErr;
   logic        oBusy;
   logic [10:0] oMemAddr;
   logic [3:0]  oMemByteEn;
   logic [31:0] oMemWData;
   logic [1:0]  oMemWren;
   logic [63:0] iMemRData;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] ram [2][2048];
   logic [31:0] rdata [2];
   logic        ram_clr = 1'b1;
   logic [7:0]  ref_mem [logic [31:0]];

   always #5 iCLK = ~iCLK;

   datamem_bus_ctrl dut (
      .iCLK        (iCLK),
      .iRST        (iRST),
      .iReq        (iReq),
      .iWrite      (iWrite),
      .iByteEnable (iByteEnable),
      .iAddress    (iAddress),
      .iWriteData  (iWriteData),
      .oReadData   (oReadData),
      .oValid      (oValid),
      .oErr        (oErr),
      .oBusy       (oBusy),
      .oMemAddr    (oMemAddr),
      .oMemByteEn  (oMemByteEn),
      .oMemWData   (oMemWData),
      .oMemWren    (oMemWren),
      .iMemRData   (iMemRData)
   );

   assign iMemRData = {rdata[1], rdata[0]};

   always @(posedge iCLK) begin
      for (int r = 0; r < 2; r++) begin
         if (ram_clr) begin
            for (int w = 0; w < 2048; w++) ram[r][w] <= 32'h0;
         end else if (oMemWren[r]) begin
            for (int b = 0; b < 4; b++)
               if (oMemByteEn[b]) ram[r][oMemAddr][b*8 +: 8] <= oMemWData[b*8 +: 8];
         end
         rdata[r] <= ram[r][oMemAddr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic int region_of(input logic [31:0] a);
      if (a >= 32'h10010000 && a <= 32'h10011FFF) return 0;
      if (a >= 32'h90000000 && a <= 32'h90000FFF) return 1;
      return -1;
   endfunction

   function automatic logic be_ok(input logic [3:0] be);
      return be == 4'b0001 || be == 4'b0010 || be == 4'b0100 || be == 4'b1000 ||
             be == 4'b0011 || be == 4'b1100 || be == 4'b1111;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      logic [31:0] v;
      logic [31:0] k;
      v = 32'h0;
      for (int b = 0; b < 4; b++) begin
         k = {a[31:2], 2'b00} + b;
         if (ref_mem.exists(k)) v[b*8 +: 8] = ref_mem[k];
      end
      return v;
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      for (int b = 0; b < 4; b++)
         if (be[b]) ref_mem[{a[31:2], 2'b00} + b] = d[b*8 +: 8];
   endtask

   function automatic logic exp_error(input logic [31:0] a, input logic [3:0] be);
      logic e;
      e = (region_of(a) < 0);
`ifdef DATAMEM_BUS_ALIGN_CHECK_EN
      if (!be_ok(be)) e = 1'b1;
`else
      if (be_ok(be) && 1'b0) e = 1'b1;
`endif
      return e;
   endfunction

   task automatic do_txn(input logic wr, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wd, input bit poke);
      logic        e;
      logic [1:0]  exp_wren;
      logic [31:0] exp_rd;
      e        = exp_error(addr, be);
      exp_wren = 2'b00;
      if (wr && !e) exp_wren = (region_of(addr) == 0) ? 2'b01 : 2'b10;
      exp_rd   = (!wr && !e) ? model_read(addr) : 32'h0;

      @(negedge iCLK);
      check("busy_before_req", {31'h0, oBusy}, 32'h0);
      iReq = 1'b1; iWrite = wr; iByteEnable = be; iAddress = addr; iWriteData = wd;
      @(posedge iCLK); #1;
      if (poke) begin
         // A competing request while busy must be ignored
         iWrite = 1'b1; iByteEnable = 4'hF;
         iAddress = 32'h10010000 + {$urandom_range(0, 15), 2'b00};
         iWriteData = $urandom;
      end else begin
         iReq = 1'b0;
      end
      check("access_wren", {30'h0, oMemWren}, {30'h0, exp_wren});
      check("access_addr", {21'h0, oMemAddr}, {21'h0, addr[12:2]});
      check("access_be", {28'h0, oMemByteEn}, {28'h0, be});
      if (wr) check("access_wdata", oMemWData, wd);
      check("access_valid", {31'h0, oValid}, 32'h0);
      check("access_busy", {31'h0, oBusy}, 32'h1);
      @(posedge iCLK); #1;
      if (wr && !e) model_write(addr, be, wd);
      check("resp_valid", {31'h0, oValid}, 32'h1);
      check("resp_err", {31'h0, oErr}, {31'h0, e});
      check("resp_rdata", oReadData, exp_rd);
      check("resp_wren", {30'h0, oMemWren}, 32'h0);
      check("resp_busy", {31'h0, oBusy}, 32'h1);
      @(posedge iCLK); #1;
      iReq = 1'b0;
      check("idle_valid", {31'h0, oValid}, 32'h0);
      check("idle_busy", {31'h0, oBusy}, 32'h0);
      check("idle_rdata_hold", oReadData, exp_rd);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] outside [4];
      int          sel;
      outside[0] = 32'h10012000; outside[1] = 32'h1000FFFC;
      outside[2] = 32'h90001000; outside[3] = 32'h8FFFFFFC;

      repeat (3) @(posedge iCLK);
      #1;
      check("rst_valid", {31'h0, oValid}, 32'h0);
      check("rst_err", {31'h0, oErr}, 32'h0);
      check("rst_busy", {31'h0, oBusy}, 32'h0);
      check("rst_wren", {30'h0, oMemWren}, 32'h0);
      check("rst_rdata", oReadData, 32'h0);
      check("rst_addr", {21'h0, oMemAddr}, 32'h0);
      check("rst_be", {28'h0, oMemByteEn}, 32'h0);
      check("rst_wdata", oMemWData, 32'h0);
      iRST = 1'b0; ram_clr = 1'b0;

      do_txn(1'b1, 4'hF, 32'h10010004, 32'hDEADBEEF, 1'b0);
      do_txn(1'b0, 4'hF, 32'h10010004, 32'h0, 1'b0);
      do_txn(1'b1, 4'hF, 32'h90000010, 32'h12345678, 1'b0);
      do_txn(1'b0, 4'hF, 32'h90000010, 32'h0, 1'b1);
      do_txn(1'b1, 4'hF, 32'h00400000, 32'hCAFEF00D, 1'b0);
      do_txn(1'b1, 4'b0101, 32'h10010000, 32'hA5A5A5A5, 1'b0);
      do_txn(1'b0, 4'hF, 32'h10010000, 32'h0, 1'b0);
      do_txn(1'b0, 4'hF, 32'h10011FFC, 32'h0, 1'b0);

      // Reset while ACCESS: the write strobe was already out, then everything aborts
      @(negedge iCLK);
      iReq = 1'b1; iWrite = 1'b1; iByteEnable = 4'hF; iAddress = 32'h10010008; iWriteData = 32'h0BADF00D;
      @(posedge iCLK); #1;
      iReq = 1'b0;
      check("rst_mid_wren_acc", {30'h0, oMemWren}, 32'h1);
      model_write(32'h10010008, 4'hF, 32'h0BADF00D);
      iRST = 1'b1;
      @(posedge iCLK); #1;
      iRST = 1'b0;
      check("rst_mid_wren", {30'h0, oMemWren}, 32'h0);
      check("rst_mid_valid", {31'h0, oValid}, 32'h0);
      check("rst_mid_busy", {31'h0, oBusy}, 32'h0);
      check("rst_mid_rdata", oReadData, 32'h0);
      check("rst_mid_addr", {21'h0, oMemAddr}, 32'h0);
      @(posedge iCLK); #1;
      check("rst_mid_after_valid", {31'h0, oValid}, 32'h0);
      do_txn(1'b0, 4'hF, 32'h10010008, 32'h0, 1'b0);

      for (int i = 0; i < 80; i++) begin
         sel = $urandom_range(0, 9);
         if (sel < 4)
            a = 32'h10010000 + ((sel == 3) ? 32'h1FC0 : 32'h0) + {$urandom_range(0, 15), 2'b00} + $urandom_range(0, 3);
         else if (sel < 8)
            a = 32'h90000000 + ((sel == 7) ? 32'h0FC0 : 32'h0) + {$urandom_range(0, 15), 2'b00} + $urandom_range(0, 3);
         else if (sel == 8)
            a = outside[$urandom_range(0, 3)];
         else
            a = $urandom;
         do_txn(1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) < 6) ? 4'hF : 4'($urandom_range(0, 15)),
                a, $urandom, ($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/datamem_bus_ctrl.md
DATAMEM_BUS_CTRL -- requirements
Module: datamem_bus_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGIONS, default 2, number of memory regions (1..8).
REQ-002 SHALL have parameter REGION_AW, default 11, word-address bits driven to each region.
REQ-003 SHALL have parameter REGION_BASE, default {32'h90000000, 32'h10010000}, packed NUM_REGIONS*32 base byte addresses (index 0 in LSBs).
REQ-004 SHALL have parameter REGION_LIMIT, default {32'h90000FFF, 32'h10011FFF}, packed NUM_REGIONS*32 inclusive limit byte addresses.
REQ-005 SHALL use one clock and a synchronous, active-high reset: iCLK  in  1  sole clock, all state updates on rising edge.
REQ-006 iRST  in  1  synchronous active-high reset.
REQ-007 iReq  in  1  request strobe, accepted when iReq && !oBusy.
REQ-008 iWrite  in  1  1 = write, 0 = read; sampled at accept.
REQ-009 iByteEnable  in  4  byte lanes; sampled at accept.
REQ-010 iAddress  in  32  byte address; sampled at accept.
REQ-011 iWriteData  in  32  write data; sampled at accept.
REQ-012 oReadData  out  32  read data, valid while oValid.
REQ-013 oValid  out  1  one-cycle completion pulse for every accepted request.
REQ-014 oErr  out  1  error flag, qualified by oValid.
REQ-015 oBusy  out  1  high whenever state is not IDLE.
REQ-016 oMemAddr  out  REGION_AW  registered word address (iAddress[REGION_AW+1:2]) shared by all regions.
REQ-017 oMemByteEn  out  4  registered byte enables, shared.
REQ-018 oMemWData  out  32  registered write data, shared.
REQ-019 oMemWren  out  NUM_REGIONS  one-hot write enable, at most one bit high.
REQ-020 iMemRData  in  NUM_REGIONS*32  per-region synchronous RAM read data (1-cycle RAM latency on iCLK).

Function
REQ-021 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE, one cycle per state.
REQ-022 IDLE: on accept (cycle N), SHALL register address, byte enables, data, direction and decoded region index/hit; else remain IDLE.
REQ-023 ACCESS (N+1): SHALL drive oMem* from registers; oMemWren[r] high only for a write that hit region r and is not an error.
REQ-024 RESP (N+2): SHALL pulse oValid; for reads oReadData = iMemRData slice of hit region, else 32'h0; oReadData holds its last value otherwise.
REQ-025 Decode: region r hits when REGION_BASE[r] <= addr <= REGION_LIMIT[r]; overlapping regions resolve to lowest index.
REQ-026 Unmapped address SHALL complete with oValid, oErr=1, read data 32'h0, no oMemWren.
REQ-027 Requests presented while oBusy SHALL be ignored (no queuing); requester holds iReq until accepted.
REQ-028 Throughput SHALL be one request per 3 cycles; read and write latency both 2 cycles accept-to-oValid.

Reset
REQ-029 iRST SHALL force IDLE and clear oValid, oErr, oBusy, oMemWren, oReadData, oMemAddr, oMemByteEn, oMemWData to 0 at the next edge.
REQ-030 Reset during ACCESS or RESP SHALL abort the request: no oValid pulse, no oMemWren in the following cycle.

Configuration
REQ-031 Macro DATAMEM_BUS_ALIGN_CHECK_EN defined: byte enables not in {0001,0010,0100,1000,0011,1100,1111} SHALL complete with oErr=1, no write, read data 32'h0.
REQ-032 Macro undefined: no alignment check; oErr SHALL assert only for unmapped addresses.

Structure
REQ-033 Package datamem_bus_pkg SHALL hold the FSM state enum, default base/limit constants, and the legal byte-enable list.
REQ-034 Sub-module datamem_region_decode SHALL compute hit and region index combinationally from address and parameters.

Verification
REQ-035 Write 0x10010004, BE 1111, data 0xDEADBEEF -> oMemWren=2'b01, oMemAddr=1 at N+1; oValid, oErr=0 at N+2.
REQ-036 Read 0x10010004 after REQ-035 -> oReadData=0xDEADBEEF, oErr=0 at N+2.
REQ-037 Read 0x90000010, region 1 returns 0x12345678 -> oReadData=0x12345678 at N+2, oMemWren=0.
REQ-038 Write 0x00400000 (unmapped) -> oMemWren=0 throughout; oValid, oErr=1, oReadData=0 at N+2.
REQ-039 With DATAMEM_BUS_ALIGN_CHECK_EN, write 0x10010000 BE 0101 -> no oMemWren, oErr=1; without macro -> oMemWren=2'b01, oErr=0.
REQ-040 iRST asserted at N+1 of a write -> no oMemWren at N+2, no oValid, state IDLE, oBusy=0.
